// File: rtl/regbank_wr_arbiter.sv
// Write-port controller for the 32 x 64 register bank: round-robin ALU/load
// writeback arbitration, XZR discard, and a pending-write hazard scoreboard.
module regbank_wr_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          iss_set,
  input  logic [AW-1:0] iss_addr,
  input  logic [AW-1:0] qa,
  input  logic [AW-1:0] qb,
  output logic          hz_a,
  output logic          hz_b,
  output logic          w,
  output logic [AW-1:0] c,
  output logic [DW-1:0] DataC,
  output logic          idle
);

  localparam int NREG = (1 << AW) - 1;
  localparam logic [AW-1:0] XZR = {AW{1'b1}};

  logic            last_grant;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic [NREG:0]   set_vec;
  logic [NREG:0]   clr_vec;
  logic [NREG:0]   pend_ext;
  logic            grant_any;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;

  // Ready is held low during reset so nothing is accepted that would be lost.
  assign alu_ready = Rst_n && alu_valid && (!mem_valid || last_grant);
  assign mem_ready = Rst_n && mem_valid && (!alu_valid || !last_grant);
  assign grant_any = alu_ready || mem_ready;
  assign g_addr    = mem_ready ? mem_addr : alu_addr;
  assign g_data    = mem_ready ? mem_data : alu_data;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_set && iss_addr != XZR) set_vec[iss_addr] = 1'b1;
    if (w && c != XZR)              clr_vec[c]        = 1'b1;
    // Set is applied after clear: the newer producer is still outstanding.
    pending_next = (pending & ~clr_vec[NREG-1:0]) | set_vec[NREG-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_grant <= 1'b1;
      w          <= 1'b0;
      c          <= '0;
      DataC      <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_next;
      w       <= 1'b0;
      if (grant_any) begin
        last_grant <= mem_ready;
        if (g_addr != XZR) begin
          w     <= 1'b1;
          c     <= g_addr;
          DataC <= g_data;
        end
      end
    end
  end

  assign pend_ext = {1'b0, pending};
  assign hz_a     = (qa != XZR) && pend_ext[qa];
  assign hz_b     = (qb != XZR) && pend_ext[qb];
  assign idle     = (pending == '0) && !alu_valid && !mem_valid && !w;

endmodule
